// File: rtl/custom_ip_req_arbiter.sv
// Round-robin arbiter that serialises register reads/writes from several
// requesters onto the single req/ack port of the custom IP, with a watchdog
// that turns a missing acknowledge into an error response.
module custom_ip_req_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned DW             = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_we_i,
    input  logic [2*NUM_REQ-1:0]    req_addr_i,
    input  logic [DW*NUM_REQ-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]           rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    ip_req_o,
    output logic                    ip_we_o,
    output logic [1:0]              ip_addr_o,
    output logic [DW-1:0]           ip_wdata_o,
    input  logic                    ip_ack_i,
    input  logic [DW-1:0]           ip_rdata_i
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]      CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
    localparam logic [IW-1:0]      LAST_RST = IW'(NUM_REQ - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  last_grant_q, grant_q;
    logic [IW-1:0]  win_c, idx_c;
    logic           found_c;
    logic [CW-1:0]  cnt_q;
    logic           accept_c, ack_c, timeout_c;
    logic           sel_we_c;
    logic [1:0]     sel_addr_c;
    logic [DW-1:0]  sel_wdata_c;

    logic [1:0]     addr_arr  [NUM_REQ];
    logic [DW-1:0]  wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr_i[2*i +: 2];
        assign wdata_arr[i] = req_wdata_i[DW*i +: DW];
    end

    // Pick the first valid requester after the last one served
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx_c = IW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!found_c && req_valid_i[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    // Fields of the current winner
    always_comb begin
        sel_we_c    = req_we_i[win_c];
        sel_addr_c  = addr_arr[win_c];
        sel_wdata_c = wdata_arr[win_c];
    end

    // Next-state and accept strobe
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        ack_c       = 1'b0;
        timeout_c   = 1'b0;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (found_c && rst_ni) begin
                    accept_c    = 1'b1;
                    req_ready_o = ONE << win_c;
                    state_d     = (sel_addr_c == 2'd3) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                ack_c     = ip_ack_i;
                timeout_c = !ip_ack_i && (cnt_q == CNT_MAX);
                if (ack_c || timeout_c) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request, IP drive, watchdog and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            cnt_q        <= '0;
            rsp_valid_o  <= '0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
            ip_req_o     <= 1'b0;
            ip_we_o      <= 1'b0;
            ip_addr_o    <= '0;
            ip_wdata_o   <= '0;
        end else begin
            rsp_valid_o <= '0;
            if (accept_c) begin
                grant_q    <= win_c;
                ip_we_o    <= sel_we_c;
                ip_addr_o  <= sel_addr_c;
                ip_wdata_o <= sel_wdata_c;
                if (sel_addr_c == 2'd3) begin
                    rsp_valid_o <= ONE << win_c;
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b1;
                end else begin
                    ip_req_o <= 1'b1;
                end
            end
            if (ack_c) begin
                ip_req_o    <= 1'b0;
                rsp_valid_o <= ONE << grant_q;
                rsp_rdata_o <= ip_we_o ? '0 : ip_rdata_i;
                rsp_err_o   <= 1'b0;
            end else if (timeout_c) begin
                ip_req_o    <= 1'b0;
                rsp_valid_o <= ONE << grant_q;
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b1;
            end
            if (state_q == ISSUE) begin
                cnt_q <= (ack_c || timeout_c) ? '0 : cnt_q + CW'(1);
            end
            if (state_q == RESP) begin
                last_grant_q <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_custom_ip_req_arbiter.sv
// Self-checking bench for custom_ip_req_arbiter: directed scenarios plus
// random traffic, compared every cycle against a transaction-level model.
module tb_custom_ip_req_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic         clk;
    logic         rst_n;
    logic [2:0]   valid, we;
    logic [5:0]   addr;
    logic [95:0]  wdata;
    logic         ack;
    logic [31:0]  rdin;

    logic [2:0]   ready, rsp_v;
    logic [31:0]  rsp_d;
    logic         rsp_e;
    logic         ipreq, ipwe;
    logic [1:0]   ipaddr;
    logic [31:0]  ipwd;

    custom_ip_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .DW(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid),
        .req_we_i    (we),
        .req_addr_i  (addr),
        .req_wdata_i (wdata),
        .req_ready_o (ready),
        .rsp_valid_o (rsp_v),
        .rsp_rdata_o (rsp_d),
        .rsp_err_o   (rsp_e),
        .ip_req_o    (ipreq),
        .ip_we_o     (ipwe),
        .ip_addr_o   (ipaddr),
        .ip_wdata_o  (ipwd),
        .ip_ack_i    (ack),
        .ip_rdata_i  (rdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests, fails, cyc;

    // Transaction-level model
    int          last, g, age;
    bit          busy, issuing, resp_due, hold_valid;
    bit          m_we;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    bit          m_err;

    // Observations of the DUT for the directed literal checks
    logic [2:0]  obs_v, acc_g;
    int          obs_cyc, acc_cyc, ipreq_cnt;
    logic [31:0] obs_d, obs_ipwd;
    logic        obs_e;
    logic [1:0]  obs_ipaddr;
    logic [2:0]  glog[$];
    int          gcyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        last = N - 1; busy = 0; issuing = 0; resp_due = 0; age = 0;
        m_rdata = '0; m_err = 0;
    endtask

    function automatic int winner();
        if (busy || !rst_n) return -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic advance();
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (resp_due) begin
            last = g; busy = 0; resp_due = 0;
        end else if (issuing) begin
            if (ack) begin
                m_rdata = m_we ? 32'h0 : rdin; m_err = 0;
                issuing = 0; resp_due = 1;
            end else if (age == TO - 1) begin
                m_rdata = 32'h0; m_err = 1;
                issuing = 0; resp_due = 1;
            end else begin
                age++;
            end
        end else begin
            w = winner();
            if (w >= 0) begin
                g = w; busy = 1;
                m_we = we[w]; m_addr = addr[2*w +: 2]; m_wdata = wdata[32*w +: 32];
                if (!hold_valid) valid[w] = 1'b0;
                if (m_addr == 2'd3) begin
                    m_rdata = 32'h0; m_err = 1; resp_due = 1;
                end else begin
                    issuing = 1; age = 0;
                end
            end
        end
    endtask

    // One clock: entered at posedge+1, compares just before the next edge
    task automatic step();
        int w;
        logic [2:0] e_ready, e_v;
        w       = winner();
        e_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
        e_v     = (resp_due && rst_n) ? 3'(1 << g) : 3'b000;
        #8;
        check("req_ready", 64'(ready), 64'(e_ready));
        check("ip_req",    64'(ipreq), 64'(issuing));
        check("rsp_valid", 64'(rsp_v), 64'(e_v));
        check("rsp_rdata", 64'(rsp_d), 64'(m_rdata));
        check("rsp_err",   64'(rsp_e), 64'(m_err));
        if (issuing) begin
            check("ip_we",    64'(ipwe),   64'(m_we));
            check("ip_addr",  64'(ipaddr), 64'(m_addr));
            check("ip_wdata", 64'(ipwd),   64'(m_wdata));
        end
        if (rsp_v != 3'b000) begin
            obs_v = rsp_v; obs_d = rsp_d; obs_e = rsp_e; obs_cyc = cyc;
        end
        if (ready != 3'b000) begin
            acc_g = ready; acc_cyc = cyc;
            glog.push_back(ready); gcyc.push_back(cyc);
        end
        if (ipreq) begin
            ipreq_cnt++; obs_ipaddr = ipaddr; obs_ipwd = ipwd;
        end
        @(posedge clk);
        #1;
        advance();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic set_req(input int i, input bit w_e, input logic [1:0] a, input logic [31:0] d);
        valid[i] = 1'b1; we[i] = w_e; addr[2*i +: 2] = a; wdata[32*i +: 32] = d;
    endtask

    task automatic clr_obs();
        obs_v = '0; acc_g = '0; obs_d = '0; obs_e = 1'b0; obs_ipaddr = '0; obs_ipwd = '0;
        obs_cyc = -1000; acc_cyc = -100; ipreq_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int ack_pct;
        tests = 0; fails = 0; cyc = 0; hold_valid = 0;
        valid = '0; we = '0; addr = '0; wdata = '0; ack = 1'b0; rdin = '0;
        rst_n = 1'b0;
        model_reset();
        clr_obs();
        @(posedge clk);
        #1;
        run(2);
        check("reset_ip_req",    64'(ipreq), 64'h0);
        check("reset_rsp_valid", 64'(rsp_v), 64'h0);
        check("reset_rsp_rdata", 64'(rsp_d), 64'h0);
        rst_n = 1'b1;
        run(1);

        // Single write, ack in second ISSUE cycle
        clr_obs();
        set_req(0, 1'b1, 2'd1, 32'h0000_2468);
        ack = 1'b0;
        run(2);
        ack = 1'b1; run(1);
        ack = 1'b0; run(3);
        check("wr_accept_g",  64'(acc_g), 64'h1);
        check("wr_latency",   64'(obs_cyc - acc_cyc), 64'd3);
        check("wr_rsp_valid", 64'(obs_v), 64'h1);
        check("wr_rsp_err",   64'(obs_e), 64'h0);
        check("wr_ip_addr",   64'(obs_ipaddr), 64'h1);
        check("wr_ip_wdata",  64'(obs_ipwd), 64'h2468);

        // Single read, immediate ack
        clr_obs();
        set_req(2, 1'b0, 2'd0, 32'h0);
        ack = 1'b1; rdin = 32'h0000_369C;
        run(4);
        ack = 1'b0;
        check("rd_latency",   64'(obs_cyc - acc_cyc), 64'd2);
        check("rd_rsp_valid", 64'(obs_v), 64'h4);
        check("rd_rsp_rdata", 64'(obs_d), 64'h369C);
        check("rd_rsp_err",   64'(obs_e), 64'h0);

        // Round-robin with all requesters continuously valid
        clr_obs();
        glog.delete(); gcyc.delete();
        hold_valid = 1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'd0, 32'h0);
        ack = 1'b1;
        run(12);
        hold_valid = 0; valid = '0;
        run(3);
        ack = 1'b0;
        check("rr_count_ok", 64'(glog.size() >= 4), 64'h1);
        if (glog.size() >= 4) begin
            check("rr_grant0", 64'(glog[0]), 64'h1);
            check("rr_grant1", 64'(glog[1]), 64'h2);
            check("rr_grant2", 64'(glog[2]), 64'h4);
            check("rr_grant3", 64'(glog[3]), 64'h1);
            check("rr_space01", 64'(gcyc[1] - gcyc[0]), 64'd3);
            check("rr_space23", 64'(gcyc[3] - gcyc[2]), 64'd3);
        end

        // Watchdog timeout
        clr_obs();
        ack = 1'b0;
        set_req(1, 1'b0, 2'd2, 32'h0);
        run(20);
        check("to_ip_req_cycles", 64'(ipreq_cnt), 64'd16);
        check("to_rsp_valid",     64'(obs_v), 64'h2);
        check("to_rsp_err",       64'(obs_e), 64'h1);
        check("to_rsp_rdata",     64'(obs_d), 64'h0);
        clr_obs();
        set_req(0, 1'b0, 2'd1, 32'h0);
        ack = 1'b1; rdin = 32'hA5A5_0001;
        run(4);
        ack = 1'b0;
        check("to_next_accept", 64'(acc_g), 64'h1);
        check("to_next_rsp",    64'(obs_v), 64'h1);
        check("to_next_rdata",  64'(obs_d), 64'hA5A5_0001);

        // Invalid register index
        clr_obs();
        set_req(0, 1'b1, 2'd3, 32'hDEAD_BEEF);
        run(4);
        check("inv_latency",   64'(obs_cyc - acc_cyc), 64'd1);
        check("inv_rsp_valid", 64'(obs_v), 64'h1);
        check("inv_rsp_err",   64'(obs_e), 64'h1);
        check("inv_no_ip_req", 64'(ipreq_cnt), 64'h0);

        // Reset in the middle of ISSUE
        set_req(1, 1'b0, 2'd1, 32'h0);
        ack = 1'b0;
        run(2);
        check("pre_reset_ip_req", 64'(ipreq), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_reset_ip_req", 64'(ipreq), 64'h0);
        model_reset();
        clr_obs();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'd0, 32'h0);
        run(2);
        check("reset_no_rsp", 64'(obs_v), 64'h0);
        rst_n = 1'b1;
        ack = 1'b1; rdin = 32'h1234_5678;
        run(1);
        check("post_reset_grant", 64'(acc_g), 64'h1);
        valid = '0;
        run(4);
        ack = 1'b0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       ack_pct = 50;
                1:       ack_pct = 10;
                default: ack_pct = 0;
            endcase
            for (int i = 0; i < N; i++) begin
                if (!valid[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    valid[i] = 1'b0;
                end
            end
            ack  = ($urandom_range(0, 99) < ack_pct);
            rdin = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/custom_ip_req_arbiter.md
Name: custom_ip_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the custom IP register port among NUM_REQ requesters (e.g. core, debug, DMA).
- Accepts one read or write request at a time and drives a single req/ack transaction to the IP's 3-entry register file.
- Returns the read data or a write completion to the winning requester.
- A watchdog aborts transactions the IP never acknowledges and returns an error response.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, maximum ISSUE cycles without ip_ack_i before abort (>=1).
- DW, 32, data width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_we_i  in  NUM_REQ  1=write, 0=read.
- req_addr_i  in  2*NUM_REQ  register index per requester; slice k = [2k+1:2k].
- req_wdata_i  in  DW*NUM_REQ  write data per requester.
- req_ready_o  out  NUM_REQ  accept strobe, one-hot or zero.
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the granted requester.
- rsp_rdata_o  out  DW  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  error flag, valid with rsp_valid_o.
- ip_req_o  out  1  transaction request to the IP.
- ip_we_o  out  1  write enable to the IP.
- ip_addr_o  out  2  register index to the IP.
- ip_wdata_o  out  DW  write data to the IP.
- ip_ack_i  in  1  IP completion strobe.
- ip_rdata_i  in  DW  IP read data, sampled on ip_ack_i.

Behaviour:
- Reset (rst_ni, asynchronous, active-low):
  - State = IDLE; last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ip_req_o, ip_we_o, ip_addr_o, ip_wdata_o.
  - Timeout counter = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid_i is set, the winner g is the first set bit searching upward from (last_grant+1) mod NUM_REQ.
  - req_ready_o[g]=1 combinationally in the same cycle; handshake is valid&ready.
  - On that edge: latch we, addr and wdata of g; register g.
  - If latched addr==3, go to RESP with err=1 and no IP access. Otherwise go to ISSUE.
  - req_ready_o is 0 in every state other than IDLE.
- ISSUE:
  - ip_req_o=1, with ip_we_o/ip_addr_o/ip_wdata_o driven from the latched request and held stable for the whole state.
  - On ip_ack_i=1: capture ip_rdata_i (reads) or 0 (writes), err=0, go to RESP. Ack in the first ISSUE cycle is legal.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ack: err=1, rdata=0, go to RESP.
  - ip_req_o drops to 0 the cycle after ack or timeout.
  - An ack arriving in the timeout cycle counts as success; ack takes priority.
  - The counter clears on leaving ISSUE.
- RESP:
  - rsp_valid_o[g]=1 for exactly one cycle, with rsp_rdata_o and rsp_err_o driven.
  - last_grant updates to g; return to IDLE.
  - rsp_rdata_o and rsp_err_o hold their last value afterwards.
- Latency: accept at cycle T, ip_req_o at T+1, earliest rsp_valid_o at T+2, earliest next accept at T+3.
- Requesters must hold req_* stable until accepted. Dropping valid before accept is allowed; that requester simply loses the slot.
- ip_ack_i outside ISSUE is ignored; stray acks have no effect.
- Reset mid-transaction aborts immediately: ip_req_o drops asynchronously and no response is generated.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,… and no requester waits more than NUM_REQ-1 transactions.

Test Plan:
- Single write: req0 we=1 addr=1 wdata=0x0000_2468, IP acks in the 2nd ISSUE cycle → ip_addr_o=1, ip_wdata_o=0x2468; rsp_valid_o=3'b001 at accept+3; err=0.
- Single read: req2 we=0 addr=0, IP acks immediately with 0x0000_369C → rsp_valid_o=3'b100, rsp_rdata_o=0x369C, at accept+2.
- Round-robin: all three requesters valid continuously with reads, IP acks immediately → grant order 0,1,2,0; accepts spaced 3 cycles apart.
- Timeout: req1 read addr=2, ip_ack_i tied 0 → ip_req_o high exactly 16 cycles; rsp_valid_o=3'b010 with err=1, rdata=0; next IDLE accepts normally.
- Invalid address: req0 addr=3 → ip_req_o never asserts; rsp_valid_o=3'b001, err=1, at accept+1.
- Reset mid-ISSUE: assert rst_ni=0 while ip_req_o=1 → ip_req_o=0 immediately, no rsp_valid_o; after release, requester 0 wins the first grant.
